fifo_packer: RTL and testbench



---
 rtl/fifo_packer.sv | 56 +++++
 tb/tb_fifo_packer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fifo_packer.sv
// fifo_packer: drains a first-word-fall-through fifo and packs PACK_RATIO words into one valid/ready packet
module fifo_packer #(
  parameter int DATA_WIDTH    = 4,
  parameter int PACK_RATIO    = 3,
  parameter int COUNTER_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic [DATA_WIDTH-1:0]            fifo_dout,
  input  logic                             fifo_empty_n,
  output logic                             fifo_deq,
  input  logic                             flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] pk_data,
  output logic [COUNTER_WIDTH-1:0]         pk_words,
  output logic                             pk_valid,
  input  logic                             pk_ready
);
  localparam logic [COUNTER_WIDTH-1:0] LAST = COUNTER_WIDTH'(PACK_RATIO - 1);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state, state_n;
  logic [COUNTER_WIDTH-1:0] cnt, cnt_n, words_n;
  logic [DATA_WIDTH*PACK_RATIO-1:0] data_n;
  assign pk_valid = state == HOLD;
  always_comb begin
    fifo_deq = state == FILL && fifo_empty_n && !clr && !rst;
    state_n = state;
    cnt_n = cnt;
    data_n = pk_data;
    words_n = pk_words;
    if (state == HOLD) begin
      state_n = pk_ready ? FILL : HOLD;
      data_n = pk_ready ? '0 : pk_data;
    end else begin
      if (fifo_deq) data_n[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] = fifo_dout;
      if ((fifo_deq && cnt == LAST) || (flush && (fifo_deq || cnt != '0))) begin
        state_n = HOLD;
        cnt_n = '0;
        words_n = cnt + COUNTER_WIDTH'(fifo_deq);
      end else cnt_n = cnt + COUNTER_WIDTH'(fifo_deq);
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= FILL;
      cnt <= '0;
      pk_data <= '0;
      pk_words <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pk_data <= data_n;
      pk_words <= words_n;
    end
  end
endmodule

// File: tb/tb_fifo_packer.sv
// tb_fifo_packer: scoreboard bench for fifo_packer with a behavioural fifo upstream
module tb_fifo_packer;
  logic clk, rst, clr, fifo_empty_n, fifo_deq, flush, pk_valid, pk_ready;
  logic [3:0] fifo_dout;
  logic [11:0] pk_data;
  logic [1:0] pk_words;
  typedef struct {logic [11:0] d; logic [1:0] w;} pkt_t;
  pkt_t exp_q[$];
  pkt_t e;
  logic [3:0] fq[$];
  int checks = 0, errors = 0, cyc = 0, deq_cnt = 0, first_deq = 0, last_deq = 0;
  logic deq_s;

  fifo_packer #(.DATA_WIDTH(4), .PACK_RATIO(3), .COUNTER_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .clr(clr), .fifo_dout(fifo_dout), .fifo_empty_n(fifo_empty_n),
    .fifo_deq(fifo_deq), .flush(flush), .pk_data(pk_data), .pk_words(pk_words),
    .pk_valid(pk_valid), .pk_ready(pk_ready)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void refresh();
    fifo_empty_n = fq.size() != 0;
    fifo_dout = fq.size() != 0 ? fq[0] : 4'h0;
  endfunction

  task automatic push(input logic [3:0] v);
    fq.push_back(v);
    refresh();
  endtask

  task automatic exp_pkt(input logic [11:0] d, input logic [1:0] w);
    pkt_t p;
    p.d = d;
    p.w = w;
    exp_q.push_back(p);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1);
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !pk_valid; i++) step(1);
    check("valid_timeout", {31'd0, pk_valid}, 1);
  endtask

  always @(posedge clk) begin
    deq_s = fifo_deq;
    #1;
    if (deq_s && fq.size() != 0) void'(fq.pop_front());
    refresh();
  end

  always @(negedge clk) begin
    cyc++;
    if (fifo_deq) begin
      if (deq_cnt == 0) first_deq = cyc;
      last_deq = cyc;
      deq_cnt++;
    end
    if (pk_valid && pk_ready && !rst && !clr) begin
      if (exp_q.size() == 0) check("pk_unexpected", {31'd0, pk_valid}, 0);
      else begin
        e = exp_q.pop_front();
        check("pk_data", {20'd0, pk_data}, {20'd0, e.d});
        check("pk_words", {30'd0, pk_words}, {30'd0, e.w});
      end
    end
  end

  initial begin
    rst = 1; clr = 0; flush = 0; pk_ready = 1;
    refresh();
    step(2);
    check("rst_valid", {31'd0, pk_valid}, 0);
    check("rst_data", {20'd0, pk_data}, 0);
    check("rst_words", {30'd0, pk_words}, 0);
    rst = 0;
    step(1);
    deq_cnt = 0;
    push(4'hC); push(4'hA); push(4'h5);
    exp_pkt(12'h5AC, 2'd3);
    wait_drain(20);
    check("basic_deq_cnt", deq_cnt, 3);
    check("basic_deq_span", last_deq - first_deq, 2);
    pk_ready = 0;
    push(4'hC); push(4'hA); push(4'h5); push(4'h1); push(4'h2); push(4'h3);
    exp_pkt(12'h5AC, 2'd3);
    exp_pkt(12'h321, 2'd3);
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      check("bp_deq", {31'd0, fifo_deq}, 0);
      check("bp_data", {20'd0, pk_data}, 32'h5AC);
      check("bp_valid", {31'd0, pk_valid}, 1);
      step(1);
    end
    pk_ready = 1;
    wait_drain(20);
    check("bp_fifo_empty", fq.size(), 0);
    push(4'hC); push(4'hA);
    exp_pkt(12'h0AC, 2'd2);
    step(3);
    check("fl_hold_off", {31'd0, pk_valid}, 0);
    flush = 1;
    step(1);
    flush = 0;
    wait_drain(10);
    push(4'hC); push(4'hA);
    exp_pkt(12'h0AC, 2'd2);
    step(1);
    flush = 1;
    step(1);
    flush = 0;
    wait_drain(10);
    step(2);
    flush = 1;
    step(1);
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      check("fl_empty_valid", {31'd0, pk_valid}, 0);
      step(1);
    end
    push(4'hC);
    step(1);
    push(4'hA);
    clr = 1;
    check("clr_deq", {31'd0, fifo_deq}, 0);
    step(1);
    clr = 0;
    check("clr_valid", {31'd0, pk_valid}, 0);
    push(4'h5); push(4'h1);
    exp_pkt(12'h15A, 2'd3);
    wait_drain(20);
    pk_ready = 0;
    push(4'h7); push(4'h8); push(4'h9);
    wait_valid(20);
    push(4'h4);
    pk_ready = 1;
    rst = 1;
    check("rst_deq", {31'd0, fifo_deq}, 0);
    step(1);
    rst = 0;
    check("rh_valid", {31'd0, pk_valid}, 0);
    check("rh_data", {20'd0, pk_data}, 0);
    check("rh_words", {30'd0, pk_words}, 0);
    exp_pkt(12'h004, 2'd1);
    step(2);
    flush = 1;
    step(1);
    flush = 0;
    wait_drain(10);
    step(3);
    check("final_exp_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
